fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction prefetch queue for the F stage of the 5-stage MIPS pipeline. Replaces the
//  direct PC->IM path: issues sequential fetch requests to instruction memory, buffers
//  returned words in order, and presents {ins, pc_4add} to the D pipeline register.
//  Branch/jump redirects resolved in D flush stale words. The stall input holds delivery.
// PARAMETERS
//  DEPTH     4             queue entries; also the cap on buffered + outstanding words (>=2)
//  RESET_PC  32'h0000_3000 first fetch address after reset
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  reset          in   1   synchronous, active-low (0 = reset)
//  stall          in   1   D stage holds; no instruction accepted this cycle
//  redirect       in   1   taken branch/jump resolved in D (pipeline 'change')
//  redirect_pc    in   32  target address (pipeline 'npc')
//  mem_req_valid  out  1   fetch request valid
//  mem_req_addr   out  32  word address of request
//  mem_req_ready  in   1   memory accepts request (fire = valid & ready)
//  mem_rsp_valid  in   1   in-order response word present (only while outstanding>0)
//  mem_rsp_data   in   32  instruction word
//  ins_valid      out  1   head instruction available
//  ins            out  32  head instruction word
//  pc_4add        out  32  address of head instruction + 4
// BEHAVIOUR
//  - Reset (reset==0 at edge): count=0, outstanding=0, drop_cnt=0, fetch_pc=RESET_PC,
//    state=FETCH; outputs mem_req_valid=0, ins_valid=0, ins=0, pc_4add=0 during reset cycle.
//  - Counters count, outstanding, drop_cnt: width $clog2(DEPTH+1); fetch_pc adds 4 mod 2^32.
//  - Accept = ins_valid & ~stall; pops head. Entries store {word, addr+4}.
//  - FSM FETCH: mem_req_valid = (count+outstanding < DEPTH); mem_req_addr = fetch_pc.
//    On fire: fetch_pc+=4, outstanding+=1. Response: outstanding-=1, word pushed at tail.
//  - FSM FLUSH: mem_req_valid=0; each response decrements drop_cnt and is discarded;
//    when drop_cnt reaches 0 -> FETCH (first request possible the following cycle).
//  - Redirect (either state, priority over stall): queue cleared (count=0) at the edge;
//    fetch_pc=redirect_pc; drop_cnt = outstanding + req_fire - rsp_fire (same-cycle request
//    counts stale, same-cycle response discarded); state = (that value==0) ? FETCH : FLUSH.
//    An accept in the redirect cycle is valid: D asserts redirect in the cycle it accepts
//    the delay-slot word; only younger words are discarded.
//  - Redirect while in FLUSH: fetch_pc replaced with newest redirect_pc; drop_cnt recomputed.
//  - Full: count+outstanding==DEPTH blocks requests; simultaneous pop+push keeps count.
//  - Empty: ins_valid=0; ins/pc_4add hold last value (don't-care for D).
//  - mem_req_valid may drop without fire only on redirect or reset; else addr held until fire.
//  - Reset mid-operation discards everything; memory side is reset in the same cycle.
// CONFIGURATION
//  FQ_BYPASS_EN defined: when count==0, state FETCH, no redirect and mem_rsp_valid, the
//    response drives ins_valid=1, ins=mem_rsp_data, pc_4add=addr+4 combinationally; if
//    accepted it is not enqueued. Zero-cycle response-to-D latency.
//  FQ_BYPASS_EN undefined: every response enqueued; visible on ins_valid the next cycle.
//    All outputs except mem_req_valid/addr driven from registers.
// TESTING
//  1 reset=0 two cycles, ready=1 -> mem_req_valid=0, ins_valid=0; after release first
//    request addr 0x3000, then 0x3004, 0x3008.
//  2 ready=1, rsp 1 cycle after fire, stall=0 -> ins 0x3000,0x3004,... pc_4add 0x3004,
//    0x3008,...; one accept per cycle in steady state, no gaps.
//  3 stall=1 for 8 cycles (DEPTH=4) -> count+outstanding saturates at 4, mem_req_valid=0;
//    on release 4 words delivered in address order, none lost or duplicated.
//  4 redirect to 0x3100 with 2 outstanding, rsp delayed 3 cycles -> state FLUSH, both stale
//    words dropped, ins_valid=0; next request addr 0x3100; first ins pc_4add=0x3104.
//  5 redirect same cycle as accept of 0x3004 and rsp_fire -> 0x3004 delivered, rsp
//    discarded, drop_cnt=outstanding-1, next delivered pc_4add=redirect_pc+4.
//  6 empty queue, rsp 0x2402_0001 at cycle t -> ins_valid at t with FQ_BYPASS_EN,
//    at t+1 without; both builds give identical delivered sequence.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue for the F stage.
//   Issues sequential word fetches to instruction memory, buffers the in-order
//   responses, and presents {ins, pc_4add} to the D pipeline register.
//   A redirect from D clears the queue and drops responses still in flight.
// Parameters: DEPTH (entries, also cap on buffered + outstanding), RESET_PC.
// Ports:
//   clk, reset (sync, active-low)  stall, redirect, redirect_pc  from D
//   mem_req_valid/addr/ready       request channel to instruction memory
//   mem_rsp_valid/data             in-order response channel
//   ins_valid, ins, pc_4add        head instruction to D
// Build option: define FQ_BYPASS_EN to forward a response straight to D when
//   the queue is empty (zero-cycle latency); otherwise every response is queued.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        ins_valid,
  output logic [31:0] ins,
  output logic [31:0] pc_4add
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {FETCH, FLUSH} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d, out_q, out_d, drop_q, drop_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;   // address of the next in-order response
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [31:0]   word_q [DEPTH];
  logic [31:0]   pc4_q  [DEPTH];

  logic          q_valid, byp, req_fire, accept, push, pop, rsp_live;
  logic [CW:0]   occ;
  logic [PW-1:0] head;

  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] ptr_dec(logic [PW-1:0] p);
    return (p == '0) ? PW'(DEPTH - 1) : p - 1'b1;
  endfunction

  assign q_valid  = (count_q != '0);
  assign occ      = {1'b0, count_q} + {1'b0, out_q};
  // Empty queue shows the last popped slot, so ins/pc_4add hold their value.
  assign head     = q_valid ? rd_q : ptr_dec(rd_q);
  // A response that belongs to the current fetch stream (not stale).
  assign rsp_live = mem_rsp_valid && (state_q == FETCH) && !redirect;

`ifdef FQ_BYPASS_EN
  assign byp = !q_valid && rsp_live;
`else
  assign byp = 1'b0;
`endif

  assign mem_req_valid = reset && (state_q == FETCH) && (occ < (CW+1)'(DEPTH));
  assign mem_req_addr  = fetch_pc_q;
  assign ins_valid     = reset && (q_valid || byp);
  assign ins           = !reset ? 32'h0 : (byp ? mem_rsp_data : word_q[head]);
  assign pc_4add       = !reset ? 32'h0 : (byp ? rsp_pc_q + 32'd4 : pc4_q[head]);

  assign req_fire = mem_req_valid && mem_req_ready;
  assign accept   = ins_valid && !stall;
  assign pop      = accept && q_valid;
  assign push     = rsp_live && !(byp && accept);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    out_d      = out_q + CW'(req_fire) - CW'(mem_rsp_valid);
    drop_d     = drop_q;
    fetch_pc_d = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
    rsp_pc_d   = rsp_live ? rsp_pc_q + 32'd4 : rsp_pc_q;
    rd_d       = pop ? ptr_inc(rd_q) : rd_q;
    wr_d       = push ? ptr_inc(wr_q) : wr_q;

    if (state_q == FLUSH) begin
      drop_d = drop_q - CW'(mem_rsp_valid);
      if (drop_d == '0) state_d = FETCH;
    end

    // Redirect: everything in flight after this edge is stale, including a
    // request firing this cycle; a response arriving this cycle is dropped now.
    if (redirect) begin
      count_d    = '0;
      wr_d       = rd_d;
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      drop_d     = out_d;
      state_d    = (out_d == '0) ? FETCH : FLUSH;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= FETCH;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      rd_q       <= '0;
      wr_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        pc4_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      if (push) begin
        word_q[wr_q] <= mem_rsp_data;
        pc4_q[wr_q]  <= rsp_pc_q + 32'd4;
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue (DEPTH=4).
//   Memory model: in-order responses with per-request latency; word contents
//   are a fixed function of address. Program-order model: every accepted
//   instruction must be the next sequential address since reset/redirect.
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_3000;
`ifdef FQ_BYPASS_EN
  localparam logic [31:0] BYP = 32'd1;
`else
  localparam logic [31:0] BYP = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, redirect, mem_req_ready, mem_rsp_valid;
  logic [31:0] redirect_pc, mem_rsp_data;
  logic        mem_req_valid, ins_valid;
  logic [31:0] mem_req_addr, ins, pc_4add;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .ins_valid(ins_valid), .ins(ins), .pc_4add(pc_4add)
  );

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t       pend[$];
  int          n_chk = 0, n_err = 0, cyc = 0, idle = 0;
  int          lat_min = 1, lat_max = 1;
  logic        live_en = 1'b0, prev_hold = 1'b0;
  logic [31:0] exp_pc = RPC, exp_req_pc = RPC;
  // Snapshot of the last stepped cycle, sampled before its closing edge.
  logic        s_req_v, s_ins_v, s_fire, s_rsp;
  logic [31:0] s_req_addr, s_ins, s_pc4;
  int          s_pend;

  function automatic logic [31:0] word_at(logic [31:0] a);
    return 32'h2402_0001 ^ ((a ^ 32'h0000_3100) * 32'h0001_0003);
  endfunction

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock cycle: memory drives, outputs sampled and checked, then the edge.
  task automatic step();
    if (reset && pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = word_at(pend[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
    end
    #1;
    s_req_v = mem_req_valid; s_req_addr = mem_req_addr; s_ins_v = ins_valid;
    s_ins = ins; s_pc4 = pc_4add; s_pend = pend.size();
    s_fire = mem_req_valid && mem_req_ready; s_rsp = mem_rsp_valid;
    if (!reset) begin
      chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_ins_valid", 32'(ins_valid), 32'd0);
      chk("rst_ins", ins, 32'd0);
      chk("rst_pc4", pc_4add, 32'd0);
      pend.delete();
      exp_pc = RPC; exp_req_pc = RPC; prev_hold = 1'b0; idle = 0;
    end else begin
      chk("cap", 32'(pend.size() <= DEPTH), 32'd1);
      if (prev_hold) chk("req_hold", 32'(mem_req_valid), 32'd1);
      if (mem_req_valid) chk("req_addr", mem_req_addr, exp_req_pc);
      if (ins_valid && !stall) begin
        chk("ins", ins, word_at(exp_pc));
        chk("pc4", pc_4add, exp_pc + 32'd4);
        exp_pc += 32'd4;
        idle = 0;
      end else if (!stall) idle++;
      if (live_en) chk("live", 32'(idle < 64), 32'd1);
      if (mem_rsp_valid) void'(pend.pop_front());
      if (mem_req_valid && mem_req_ready) begin
        pend.push_back('{mem_req_addr, cyc + $urandom_range(lat_max, lat_min)});
        exp_req_pc += 32'd4;
      end
      prev_hold = mem_req_valid && !mem_req_ready && !redirect;
      if (redirect) begin
        exp_pc = redirect_pc; exp_req_pc = redirect_pc;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run_until_accept(string tag, logic [31:0] exp_pc4);
    logic found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (s_ins_v && !stall) begin
        found = 1'b1;
        chk({tag, "_pc4"}, s_pc4, exp_pc4);
      end
    end
    chk({tag, "_found"}, 32'(found), 32'd1);
  endtask

  initial begin
    logic [31:0] exp_drop, t6_ins_t;
    int k = 0;
    logic seen;
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;

    // 1: reset, then first three sequential requests
    step(); step();
    reset = 1'b1;
    step(); chk("t1_v0", 32'(s_req_v), 32'd1); chk("t1_a0", s_req_addr, 32'h3000);
    step(); chk("t1_a1", s_req_addr, 32'h3004);
    step(); chk("t1_a2", s_req_addr, 32'h3008);

    // 2: steady stream, one accept per cycle
    repeat (6) step();
    for (int i = 0; i < 10; i++) begin step(); chk("t2_gap", 32'(s_ins_v), 32'd1); end

    // 3: stall saturates the queue; release delivers back to back
    stall = 1'b1;
    repeat (8) step();
    chk("t3_req_off", 32'(s_req_v), 32'd0);
    chk("t3_no_out", 32'(s_pend), 32'd0);
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin step(); chk("t3_rel", 32'(s_ins_v), 32'd1); end

    // 4: redirect with two outstanding, slow responses
    mem_req_ready = 1'b0;
    repeat (10) step();
    mem_req_ready = 1'b1; stall = 1'b1; lat_min = 3; lat_max = 3;
    step(); step();
    mem_req_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h3100;
    step();
    chk("t4_out", 32'(s_pend), 32'd2);
    redirect = 1'b0; mem_req_ready = 1'b1; stall = 1'b0; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t4_flush_req", 32'(s_req_v), 32'd0);
      chk("t4_flush_ins", 32'(s_ins_v), 32'd0);
    end
    step();
    chk("t4_req_v", 32'(s_req_v), 32'd1);
    chk("t4_req_a", s_req_addr, 32'h3100);
    run_until_accept("t4", 32'h3104);

    // 5: redirect in the same cycle as an accept and a response
    repeat (8) step();
    stall = 1'b1;
    step(); step();
    stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h4000;
    step();
    chk("t5_acc", 32'(s_ins_v), 32'd1);
    chk("t5_rsp", 32'(s_rsp), 32'd1);
    exp_drop = 32'(s_pend) + 32'(s_fire) - 32'(s_rsp);
    redirect = 1'b0;
    step();
    chk("t5_req_after", 32'(s_req_v), 32'(exp_drop == 0));
    run_until_accept("t5", 32'h4004);

    // 6: response into an empty queue: bypass latency vs registered latency
    mem_req_ready = 1'b0;
    repeat (10) step();
    redirect = 1'b1; redirect_pc = 32'h3100;
    step();
    redirect = 1'b0; mem_req_ready = 1'b1; lat_min = 2; lat_max = 2;
    step();
    mem_req_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin step(); seen = s_rsp; end
    chk("t6_rsp_seen", 32'(seen), 32'd1);
    chk("t6_vld_t", 32'(s_ins_v), BYP);
    t6_ins_t = s_ins;
    step();
    chk("t6_vld_t1", 32'(s_ins_v), 32'd1 - BYP);
    chk("t6_ins", (BYP != 0) ? t6_ins_t : s_ins, 32'h2402_0001);

    // Random traffic, with one reset in the middle
    live_en = 1'b1; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      stall         = ($urandom % 10) < 3;
      mem_req_ready = ($urandom % 10) < 7;
      redirect      = ($urandom % 100) < 3;
      if (redirect) begin
        k++;
        redirect_pc = 32'h0010_0000 * k + 32'(($urandom % 64) * 4);
      end
      reset = !(i == 1500 || i == 1501);
      step();
    end
    reset = 1'b1; redirect = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
